// File: rtl/lives_ctl.sv
// Ship-death bookkeeping: counts hits into dead_count, runs the post-hit
// invulnerability window with its blink strobe, and flags game over.
module lives_ctl #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit,
  input  logic       vsync_in,
  input  logic       restart,
  output logic [3:0] dead_count,
  output logic       invuln,
  output logic       blink,
  output logic       game_over,
  output logic       hit_ack
);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam logic [3:0] LIVES_V    = 4'(LIVES);
  localparam logic [3:0] LAST_LIFE  = 4'(LIVES - 1);
  localparam logic [7:0] INV_LAST   = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t     state;
  logic       hit_d;
  logic       vs_d;
  logic       hit_rise;
  logic       tick;
  logic [7:0] frame_cnt;
  logic [7:0] blink_cnt;

  // Edge detect: a held hit counts once, one tick per vsync rise
  assign hit_rise = hit & ~hit_d;
  assign tick     = vsync_in & ~vs_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= LIVES_V) return LIVES_V;
    return v + 4'd1;
  endfunction

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state      <= ALIVE;
      hit_d      <= 1'b0;
      vs_d       <= 1'b0;
      frame_cnt  <= 8'd0;
      blink_cnt  <= 8'd0;
      dead_count <= 4'd0;
      invuln     <= 1'b0;
      blink      <= 1'b0;
      game_over  <= 1'b0;
      hit_ack    <= 1'b0;
    end else begin
      hit_d   <= hit;
      vs_d    <= vsync_in;
      hit_ack <= 1'b0;
      if (restart) begin
        state      <= ALIVE;
        frame_cnt  <= 8'd0;
        blink_cnt  <= 8'd0;
        dead_count <= 4'd0;
        invuln     <= 1'b0;
        blink      <= 1'b0;
        game_over  <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            if (hit_rise) begin
              hit_ack    <= 1'b1;
              dead_count <= sat_inc(dead_count);
              frame_cnt  <= 8'd0;
              blink_cnt  <= 8'd0;
              if (dead_count >= LAST_LIFE) begin
                // Last life spent: no invulnerability window
                state     <= GAME_OVER;
                game_over <= 1'b1;
                invuln    <= 1'b0;
                blink     <= 1'b0;
              end else begin
                state  <= INVULN;
                invuln <= 1'b1;
                blink  <= 1'b1;
              end
            end
          end
          INVULN: begin
            if (tick) begin
              if (frame_cnt == INV_LAST) begin
                state     <= ALIVE;
                invuln    <= 1'b0;
                blink     <= 1'b0;
                frame_cnt <= 8'd0;
                blink_cnt <= 8'd0;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
                if (blink_cnt == BLINK_LAST) begin
                  blink_cnt <= 8'd0;
                  blink     <= ~blink;
                end else begin
                  blink_cnt <= blink_cnt + 8'd1;
                end
              end
            end
          end
          GAME_OVER: begin
            dead_count <= LIVES_V;
            game_over  <= 1'b1;
          end
          default: begin
            state     <= ALIVE;
            invuln    <= 1'b0;
            blink     <= 1'b0;
            game_over <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lives_ctl.sv
// Scoreboard bench for lives_ctl: stimulus pushes the expected outputs for
// each cycle, a monitor pops and compares them after every clock edge.
module tb_lives_ctl;

  logic       pclk;
  logic       rst;
  logic       hit;
  logic       vsync_in;
  logic       restart;
  logic [3:0] dead_count;
  logic       invuln;
  logic       blink;
  logic       game_over;
  logic       hit_ack;

  lives_ctl #(
    .LIVES(3),
    .INVULN_FRAMES(120),
    .BLINK_FRAMES(8)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .hit(hit),
    .vsync_in(vsync_in),
    .restart(restart),
    .dead_count(dead_count),
    .invuln(invuln),
    .blink(blink),
    .game_over(game_over),
    .hit_ack(hit_ack)
  );

  typedef struct {
    logic [3:0] dc;
    logic       inv;
    logic       bl;
    logic       go;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;

  logic [3:0] e_dc;
  logic       e_inv;
  logic       e_bl;
  logic       e_go;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_no, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge
  always @(posedge pclk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cyc_no++;
      cmp("dead_count", int'(dead_count), int'(e.dc));
      cmp("invuln", int'(invuln), int'(e.inv));
      cmp("blink", int'(blink), int'(e.bl));
      cmp("game_over", int'(game_over), int'(e.go));
      cmp("hit_ack", int'(hit_ack), int'(e.ack));
    end
  end

  task automatic cyc(input logic h, input logic v, input logic r, input logic nr,
                     input logic ack);
    exp_t e;
    @(negedge pclk);
    hit      = h;
    vsync_in = v;
    restart  = r;
    rst      = nr;
    e.dc  = e_dc;
    e.inv = e_inv;
    e.bl  = e_bl;
    e.go  = e_go;
    e.ack = ack;
    sb.push_back(e);
  endtask

  task automatic set_exp(input logic [3:0] dc, input logic inv, input logic bl,
                         input logic go);
    e_dc  = dc;
    e_inv = inv;
    e_bl  = bl;
    e_go  = go;
  endtask

  // 120 frames of invulnerability; optional hit before a tick and hit on a tick
  task automatic run_invuln(input int hit_pre, input int hit_on_tick);
    for (int k = 1; k <= 120; k++) begin
      if (k == hit_pre) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k == 120) begin
        e_inv = 1'b0;
        e_bl  = 1'b0;
      end else begin
        e_bl = ((k / 8) % 2 == 0);
      end
      cyc((k == hit_on_tick), 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    hit      = 1'b0;
    vsync_in = 1'b0;
    restart  = 1'b0;
    rst      = 1'b0;

    // Reset with hit pulsing
    set_exp(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // First hit lands together with a tick in ALIVE
    set_exp(4'd1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_invuln(20, 40);

    // Second hit, full window
    set_exp(4'd2, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_invuln(-1, -1);

    // Third hit goes straight to game over
    set_exp(4'd3, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart with a simultaneous hit rise in GAME_OVER
    set_exp(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // New game: hit, a few frames, then restart with hit rise in INVULN
    set_exp(4'd1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    set_exp(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Hit held for 1000 cycles counts once
    set_exp(4'd1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 999; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-INVULN with hit held through release
    set_exp(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_exp(4'd1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge pclk);
    @(negedge pclk);
    cmp("scoreboard_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lives_ctl.md
# lives_ctl

Ship-death bookkeeping stage that sits directly upstream of the lives-icon overlay. It counts ship hits and drives `dead_count`, the value the overlay compares against each icon's index. It also runs a post-hit invulnerability window with a blink strobe for the ship sprite, and flags game over once all lives are spent. Frame timing comes from the rising edge of the video `vsync_in`.

## Interface
Parameters:
- `LIVES`, 3: lives per game; legal range 1..15.
- `INVULN_FRAMES`, 120: frames of invulnerability after a non-fatal hit; legal range 1..255.
- `BLINK_FRAMES`, 8: frames per blink half-period; legal range 1..255.

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-low reset; `rst`=0 at a `pclk` edge resets the block.
- `hit` in 1: collision level from ship/bullet logic; rising edge = one hit.
- `vsync_in` in 1: vertical sync from the timing chain; rising edge = one frame tick.
- `restart` in 1: level, sampled each cycle; starts a new game.
- `dead_count` out 4: lives lost, 0..`LIVES`; feeds the lives overlay.
- `invuln` out 1: high while in INVULN.
- `blink` out 1: ship-sprite hide strobe; 0 outside INVULN.
- `game_over` out 1: high in GAME_OVER.
- `hit_ack` out 1: one-cycle pulse per accepted hit.

## Operation
- Edge detect:
  - `hit_d` and `vs_d` register the previous samples.
  - `hit_rise` = `hit` & ~`hit_d`.
  - `tick` = `vsync_in` & ~`vs_d`.
  - A `hit` held high counts once.
- FSM states and transitions, priority top-down:
  - Any state, `restart`=1: go to ALIVE, `dead_count`=0, counters cleared. `hit_rise` in the same cycle is ignored.
  - ALIVE, `hit_rise`, `dead_count` < `LIVES`-1: increment `dead_count`, pulse `hit_ack`, go to INVULN. `frame_cnt`=0, `blink_cnt`=0, `blink`=1.
  - ALIVE, `hit_rise`, `dead_count` = `LIVES`-1: `dead_count`=`LIVES`, pulse `hit_ack`, go directly to GAME_OVER (no invulnerability).
  - INVULN: `hit_rise` is ignored (no `hit_ack`, no count change). On `tick`, increment `frame_cnt`. When `frame_cnt` = `INVULN_FRAMES`-1 and `tick`: go to ALIVE, `blink`=0.
  - INVULN blink: on `tick`, `blink_cnt` increments. When it reaches `BLINK_FRAMES`-1 it wraps to 0 and `blink` toggles.
  - GAME_OVER: holds; ignores `hit`; `dead_count` stays `LIVES`; exits only via `restart` or reset.
- Width rules:
  - `frame_cnt` and `blink_cnt` are 8 bits and never wrap, because the parameters are capped at 255.
  - `dead_count` saturates at `LIVES` and never exceeds it.

## Timing
- All outputs are registered.
- Response to a `hit_rise` sampled at edge N is visible from edge N, i.e. in the cycle after the rising input. The same applies to `restart` and `tick`.
- `hit_ack` is high for exactly one `pclk` cycle.
- The overlay downstream applies its own 2-cycle video delay; `dead_count` only changes on hits, so no alignment to `hcount` is required.
- Reset values (`rst`=0):
  - State ALIVE.
  - `dead_count`=0, `invuln`=0, `blink`=0, `game_over`=0, `hit_ack`=0.
  - `hit_d`=0, `vs_d`=0, counters=0.
- Reset mid-INVULN or in GAME_OVER behaves exactly as the reset values above.
- Because `hit_d` resets to 0, a `hit` already high when reset releases produces a hit on the first non-reset edge.
- Simultaneous `tick` and `hit_rise` in INVULN: the tick is counted, the hit is dropped.
- Simultaneous `tick` and `hit_rise` in ALIVE: the hit is taken; the tick is irrelevant.

## Test plan
- Reset with `rst`=0 for 4 cycles, `hit` pulsing: all outputs 0, state ALIVE; `hit_ack` never asserts.
- Default parameters, single `hit` pulse in ALIVE:
  - `dead_count` 0→1, one `hit_ack`, `invuln`=1, `blink`=1.
  - `blink` toggles after 8 vsync edges.
  - `invuln` drops on the 120th vsync edge.
- Hit during INVULN, including one landing on the same cycle as a vsync edge: `dead_count` unchanged, no `hit_ack`, frame count still advances.
- Three hits, each after invulnerability ends: `dead_count` 1, 2, 3. The third hit sets `game_over`=1 with `invuln`=0. A further hit leaves `dead_count`=3.
- `restart` asserted with `hit` rising in the same cycle, in GAME_OVER and again in INVULN: `dead_count`=0, state ALIVE, no `hit_ack`.
- `hit` held high for 1000 cycles in ALIVE: exactly one `hit_ack` and `dead_count`=1.
